// File: rtl/hicore_biu_arb.sv
// hicore_biu_arb: two-master ICB arbiter in front of the HiCore BIU slave port.
//   m0_icb_*  : instruction-fetch master (IFU), cmd in / rsp out
//   m1_icb_*  : load/store master (LSU), cmd in / rsp out
//   o_icb_*   : shared command/response channel towards the BIU
// Commands are granted round-robin (or LSU-first when LSU_PRIO=1). A small
// source-ID FIFO records the issuer of each outstanding command so in-order
// responses are steered back. clk/rst: single clock, synchronous active-high reset.
module hicore_biu_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned LSU_PRIO   = 0
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,

  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,

  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic [DW-1:0]   o_icb_rsp_rdata
);

  localparam int unsigned PtrW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUTS_DEPTH + 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUTS_DEPTH-1:0] fifo_q, fifo_d;
  logic                  lock_q, lock_d;
  logic                  gnt_q, gnt_d;
  logic                  rr_last_q, rr_last_d;

  logic gnt, gnt_valid, block, cmd_rdy, nonempty, head, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant: frozen while a command is stalled, otherwise fixed or round-robin.
  always_comb begin
    if (lock_q) begin
      gnt = gnt_q;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      gnt = (LSU_PRIO != 0) ? 1'b1 : ~rr_last_q;
    end else begin
      gnt = m1_icb_cmd_valid;
    end
  end

  always_comb begin
    // No pass-through when full: a same-cycle pop does not free a slot.
    block     = (cnt_q == CntW'(OUTS_DEPTH));
    gnt_valid = gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    o_icb_cmd_valid  = ~rst & ~block & gnt_valid;
    cmd_rdy          = ~rst & ~block & o_icb_cmd_ready;
    m0_icb_cmd_ready = cmd_rdy & ~gnt;
    m1_icb_cmd_ready = cmd_rdy & gnt;
    o_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    o_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    o_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    o_icb_cmd_wmask  = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    // A response with nothing outstanding is ignored entirely.
    nonempty         = ~rst & (cnt_q != '0);
    head             = fifo_q[rd_ptr_q];
    m0_icb_rsp_valid = nonempty & o_icb_rsp_valid & ~head;
    m1_icb_rsp_valid = nonempty & o_icb_rsp_valid & head;
    o_icb_rsp_ready  = nonempty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    m0_icb_rsp_err   = o_icb_rsp_err;
    m1_icb_rsp_err   = o_icb_rsp_err;
    m0_icb_rsp_rdata = o_icb_rsp_rdata;
    m1_icb_rsp_rdata = o_icb_rsp_rdata;

    push = o_icb_cmd_valid & o_icb_cmd_ready;
    pop  = o_icb_rsp_valid & o_icb_rsp_ready;
  end

  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fifo_d    = fifo_q;
    lock_d    = lock_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;

    if (push) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_last_d        = gnt;
      lock_d           = 1'b0;
    end else if (o_icb_cmd_valid) begin
      lock_d = 1'b1;
      gnt_d  = gnt;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fifo_q    <= '0;
      lock_q    <= 1'b0;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fifo_q    <= fifo_d;
      lock_q    <= lock_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_hicore_biu_arb.sv
// Self-checking bench for hicore_biu_arb: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based model of the arbiter.
module tb_hicore_biu_arb;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned OUTS_DEPTH = 2;
  localparam int unsigned LSU_PRIO   = 0;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [AW-1:0]   m0_icb_cmd_addr;
  logic [DW-1:0]   m0_icb_cmd_wdata;
  logic [DW/8-1:0] m0_icb_cmd_wmask;
  logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [DW-1:0]   m0_icb_rsp_rdata;
  logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [AW-1:0]   m1_icb_cmd_addr;
  logic [DW-1:0]   m1_icb_cmd_wdata;
  logic [DW/8-1:0] m1_icb_cmd_wmask;
  logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [DW-1:0]   m1_icb_rsp_rdata;
  logic            o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [AW-1:0]   o_icb_cmd_addr;
  logic [DW-1:0]   o_icb_cmd_wdata;
  logic [DW/8-1:0] o_icb_cmd_wmask;
  logic            o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [DW-1:0]   o_icb_rsp_rdata;

  always #5 clk = ~clk;

  hicore_biu_arb #(
    .AW(AW), .DW(DW), .OUTS_DEPTH(OUTS_DEPTH), .LSU_PRIO(LSU_PRIO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_read(o_icb_cmd_read), .o_icb_cmd_addr(o_icb_cmd_addr),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Model state: source IDs of outstanding commands, last winner, held grant.
  bit mq[$];
  bit rr_last;
  int lock_src;

  // Per-cycle model outputs.
  bit e_gnt, e_ocv, e_push, e_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: derive expected outputs from the model and compare everything.
  task automatic eval_cycle();
    bit full, gv, rdy, ne, head, orr;
    #4;
    full = (mq.size() == OUTS_DEPTH);
    if (lock_src >= 0) e_gnt = lock_src[0];
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid) e_gnt = (LSU_PRIO != 0) ? 1'b1 : !rr_last;
    else e_gnt = m1_icb_cmd_valid;
    gv    = e_gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    e_ocv = !rst && !full && gv;
    rdy   = !rst && !full && o_icb_cmd_ready;
    ne    = !rst && (mq.size() > 0);
    head  = (mq.size() > 0) ? mq[0] : 1'b0;
    orr   = ne && (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    chk("o_cmd_valid", 64'(o_icb_cmd_valid), 64'(e_ocv));
    chk("m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'(rdy && !e_gnt));
    chk("m1_cmd_ready", 64'(m1_icb_cmd_ready), 64'(rdy && e_gnt));
    if (e_ocv) begin
      chk("o_cmd_read", 64'(o_icb_cmd_read), 64'(e_gnt ? m1_icb_cmd_read : m0_icb_cmd_read));
      chk("o_cmd_addr", 64'(o_icb_cmd_addr), 64'(e_gnt ? m1_icb_cmd_addr : m0_icb_cmd_addr));
      chk("o_cmd_wdata", 64'(o_icb_cmd_wdata),
          64'(e_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata));
      chk("o_cmd_wmask", 64'(o_icb_cmd_wmask),
          64'(e_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask));
    end
    chk("m0_rsp_valid", 64'(m0_icb_rsp_valid), 64'(ne && o_icb_rsp_valid && !head));
    chk("m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'(ne && o_icb_rsp_valid && head));
    chk("o_rsp_ready", 64'(o_icb_rsp_ready), 64'(orr));
    chk("m0_rsp_rdata", 64'(m0_icb_rsp_rdata), 64'(o_icb_rsp_rdata));
    chk("m1_rsp_rdata", 64'(m1_icb_rsp_rdata), 64'(o_icb_rsp_rdata));
    chk("m0_rsp_err", 64'(m0_icb_rsp_err), 64'(o_icb_rsp_err));
    chk("m1_rsp_err", 64'(m1_icb_rsp_err), 64'(o_icb_rsp_err));
    e_push = e_ocv && o_icb_cmd_ready;
    e_pop  = o_icb_rsp_valid && orr;
  endtask

  // Apply this cycle's handshakes to the model, then move to the next cycle.
  task automatic adv();
    if (rst) begin
      mq.delete();
      rr_last  = 1'b0;
      lock_src = -1;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back(e_gnt);
        rr_last  = e_gnt;
        lock_src = -1;
      end else if (e_ocv) begin
        lock_src = int'(e_gnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = '0;
    m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = '0;
    m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 0;
    o_icb_cmd_ready = 0; o_icb_rsp_valid = 0; o_icb_rsp_err = 0; o_icb_rsp_rdata = '0;
  endtask

  task automatic set_m0(input bit v, input logic [AW-1:0] a);
    m0_icb_cmd_valid = v; m0_icb_cmd_read = 1; m0_icb_cmd_addr = a;
    m0_icb_cmd_wdata = 32'h0000_00A0; m0_icb_cmd_wmask = 4'hF;
  endtask

  task automatic set_m1(input bit v, input logic [AW-1:0] a);
    m1_icb_cmd_valid = v; m1_icb_cmd_read = 0; m1_icb_cmd_addr = a;
    m1_icb_cmd_wdata = 32'hB1B1_0000; m1_icb_cmd_wmask = 4'h3;
  endtask

  task automatic rsp(input bit v, input logic [DW-1:0] d);
    o_icb_rsp_valid = v; o_icb_rsp_rdata = d;
    m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
  endtask

  bit hold0, hold1;

  initial begin
    mq.delete();
    rr_last  = 0;
    lock_src = -1;
    idle();
    rst = 1;
    @(posedge clk); #1;
    // Reset held with traffic present: every valid/ready stays low.
    set_m0(1, 32'h8000_0000); o_icb_cmd_ready = 1; rsp(1, 32'hDEAD_BEEF);
    eval_cycle();
    chk("rst_o_cmd_valid", 64'(o_icb_cmd_valid), 64'd0);
    chk("rst_m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'd0);
    chk("rst_o_rsp_ready", 64'(o_icb_rsp_ready), 64'd0);
    adv();
    rst = 0;
    idle();

    // Single IFU read, same-cycle issue, response routed to m0.
    set_m0(1, 32'h8000_0000); o_icb_cmd_ready = 1;
    eval_cycle();
    chk("t1_o_cmd_valid", 64'(o_icb_cmd_valid), 64'd1);
    chk("t1_m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'd1);
    chk("t1_o_cmd_addr", 64'(o_icb_cmd_addr), 64'h8000_0000);
    adv();
    idle(); rsp(1, 32'h1234_5678);
    eval_cycle();
    chk("t1_m0_rsp_valid", 64'(m0_icb_rsp_valid), 64'd1);
    chk("t1_m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'd0);
    chk("t1_m0_rdata", 64'(m0_icb_rsp_rdata), 64'h1234_5678);
    adv();

    // Both masters contend; responses drain every cycle: grants m1,m0,m1,m0.
    for (int i = 0; i < 4; i++) begin
      idle();
      set_m0(1, 32'h100 + 32'(i)); set_m1(1, 32'h200 + 32'(i)); o_icb_cmd_ready = 1;
      rsp(i != 0, 32'(i));
      eval_cycle();
      chk("t2_m1_granted", 64'(m1_icb_cmd_ready), 64'((i % 2) == 0));
      chk("t2_m0_granted", 64'(m0_icb_cmd_ready), 64'((i % 2) == 1));
      if (i != 0) chk("t2_rsp_to_prev", 64'(m1_icb_rsp_valid), 64'((i % 2) == 1));
      adv();
      chk("t2_cnt_le_1", 64'(mq.size() <= 1), 64'd1);
    end
    idle(); rsp(1, 32'h55);
    eval_cycle();
    chk("t2_drain_m0", 64'(m0_icb_rsp_valid), 64'd1);
    adv();

    // Stall with m0 granted; m1 arrives mid-stall but must wait.
    for (int i = 0; i < 4; i++) begin
      idle();
      set_m0(1, 32'h0000_3000);
      if (i >= 1) set_m1(1, 32'h0000_4000);
      o_icb_cmd_ready = (i == 3);
      eval_cycle();
      chk("t4_addr_m0", 64'(o_icb_cmd_addr), 64'h0000_3000);
      chk("t4_m1_ready0", 64'(m1_icb_cmd_ready), 64'd0);
      adv();
    end
    idle(); set_m1(1, 32'h0000_4000); o_icb_cmd_ready = 1;
    eval_cycle();
    chk("t4_m1_next", 64'(m1_icb_cmd_ready), 64'd1);
    chk("t4_addr_m1", 64'(o_icb_cmd_addr), 64'h0000_4000);
    adv();
    for (int i = 0; i < 2; i++) begin
      idle(); rsp(1, 32'(i));
      eval_cycle();
      adv();
    end

    // Fill to OUTS_DEPTH, third held; in-order responses; pop doesn't unblock.
    idle(); set_m0(1, 32'h10); o_icb_cmd_ready = 1; eval_cycle(); adv();
    idle(); set_m1(1, 32'h20); o_icb_cmd_ready = 1; eval_cycle(); adv();
    idle(); set_m0(1, 32'h30); o_icb_cmd_ready = 1;
    eval_cycle();
    chk("t3_full_ready0", 64'(m0_icb_cmd_ready), 64'd0);
    chk("t3_full_valid0", 64'(o_icb_cmd_valid), 64'd0);
    adv();
    rsp(1, 32'hA);
    eval_cycle();
    chk("t5_pop_no_pass", 64'(m0_icb_cmd_ready), 64'd0);
    chk("t3_rsp_a_m0", 64'(m0_icb_rsp_valid), 64'd1);
    chk("t3_rsp_a_m1", 64'(m1_icb_rsp_valid), 64'd0);
    adv();
    chk("t5_cnt_1", 64'(mq.size()), 64'd1);
    rsp(0, 32'h0);
    eval_cycle();
    chk("t5_accept_next", 64'(m0_icb_cmd_ready), 64'd1);
    adv();
    chk("t5_cnt_2", 64'(mq.size()), 64'd2);
    idle(); rsp(1, 32'hB);
    eval_cycle();
    chk("t3_rsp_b_m1", 64'(m1_icb_rsp_valid), 64'd1);
    chk("t3_rdata_b", 64'(m1_icb_rsp_rdata), 64'hB);
    adv();
    idle(); set_m1(1, 32'h40); o_icb_cmd_ready = 1; eval_cycle(); adv();

    // Reset with two outstanding: bookkeeping gone, first tie goes to m1.
    idle(); rst = 1; eval_cycle(); adv();
    rst = 0; rsp(1, 32'h77);
    eval_cycle();
    chk("t6_no_rsp_valid", 64'(m0_icb_rsp_valid | m1_icb_rsp_valid), 64'd0);
    chk("t6_rsp_ready0", 64'(o_icb_rsp_ready), 64'd0);
    adv();
    idle(); set_m0(1, 32'h50); set_m1(1, 32'h60); o_icb_cmd_ready = 1;
    eval_cycle();
    chk("t6_tie_m1", 64'(m1_icb_cmd_ready), 64'd1);
    chk("t6_tie_addr", 64'(o_icb_cmd_addr), 64'h60);
    adv();

    // Randomized traffic; commands are held until accepted.
    idle();
    hold0 = 0; hold1 = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!hold0) begin
        m0_icb_cmd_valid = $urandom_range(0, 1);
        m0_icb_cmd_read  = $urandom_range(0, 1);
        m0_icb_cmd_addr  = $urandom;
        m0_icb_cmd_wdata = $urandom;
        m0_icb_cmd_wmask = 4'($urandom);
      end
      if (!hold1) begin
        m1_icb_cmd_valid = $urandom_range(0, 1);
        m1_icb_cmd_read  = $urandom_range(0, 1);
        m1_icb_cmd_addr  = $urandom;
        m1_icb_cmd_wdata = $urandom;
        m1_icb_cmd_wmask = 4'($urandom);
      end
      o_icb_cmd_ready  = ($urandom_range(0, 9) < 6);
      o_icb_rsp_valid  = $urandom_range(0, 1);
      o_icb_rsp_err    = $urandom_range(0, 1);
      o_icb_rsp_rdata  = $urandom;
      m0_icb_rsp_ready = ($urandom_range(0, 3) != 0);
      m1_icb_rsp_ready = ($urandom_range(0, 3) != 0);
      eval_cycle();
      hold0 = !rst && m0_icb_cmd_valid && !(e_push && !e_gnt);
      hold1 = !rst && m1_icb_cmd_valid && !(e_push && e_gnt);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
